// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - execute-stage slice: PC adders, ALU with operand-B mux, branch decision
// Results are combinational; a small status register keeps the last result and flags.
module exec_unit #(
    parameter int WIDTH  = 32,
    parameter int PC_INC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             alu_src,
    input  logic [3:0]       alu_op,
    input  logic             pc_src,
    output logic [WIDTH-1:0] norm_iaddr,
    output logic [WIDTH-1:0] branch_iaddr,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             branch_taken,
    output logic [WIDTH-1:0] alu_q,
    output logic [2:0]       flags_q
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_LUI  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] opB;
    logic [WIDTH:0]   sumExt;
    logic [WIDTH:0]   diffExt;
    logic [4:0]       shamt;

    assign opB   = alu_src ? imm : data2;
    assign shamt = opB[4:0];

    // Subtraction as A + ~B + 1 so the carry-out reads as "no borrow".
    assign sumExt  = {1'b0, data1} + {1'b0, opB};
    assign diffExt = {1'b0, data1} + {1'b0, ~opB} + {{WIDTH{1'b0}}, 1'b1};

    assign norm_iaddr   = pc_in + WIDTH'(PC_INC);
    assign branch_iaddr = norm_iaddr + imm;

    always_comb begin
        alu_out  = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (alu_op)
            OP_AND:  alu_out = data1 & opB;
            OP_OR:   alu_out = data1 | opB;
            OP_ADD: begin
                alu_out  = sumExt[WIDTH-1:0];
                carry    = sumExt[WIDTH];
                overflow = (data1[MSB] == opB[MSB]) && (sumExt[MSB] != data1[MSB]);
            end
            OP_XOR:  alu_out = data1 ^ opB;
            OP_SLL:  alu_out = data1 << shamt;
            OP_SRL:  alu_out = data1 >> shamt;
            OP_SUB: begin
                alu_out  = diffExt[WIDTH-1:0];
                carry    = diffExt[WIDTH];
                overflow = (data1[MSB] != opB[MSB]) && (diffExt[MSB] != data1[MSB]);
            end
            OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(opB))};
            OP_SRA:  alu_out = $signed(data1) >>> shamt;
            OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (data1 < opB)};
            OP_LUI:  alu_out = opB << 16;
            OP_NOR:  alu_out = ~(data1 | opB);
            default: alu_out = '0;
        endcase
    end

    assign zero         = (alu_out == '0);
    assign branch_taken = zero & pc_src;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_q   <= '0;
            flags_q <= 3'b000;
        end else begin
            alu_q   <= alu_out;
            flags_q <= {overflow, carry, zero};
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - self-checking bench for exec_unit with directed and randomized cases
module tb_exec_unit;

    localparam logic [3:0] ADD  = 4'b0010;
    localparam logic [3:0] SUB  = 4'b0110;
    localparam logic [3:0] SLT  = 4'b0111;
    localparam logic [3:0] SRA  = 4'b1000;
    localparam logic [3:0] SLTU = 4'b1001;
    localparam logic [3:0] LUI  = 4'b1010;
    localparam logic [3:0] NOR  = 4'b1100;

    localparam longint S32MAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint S32MIN = -64'sh0000_0000_8000_0000;
    localparam longint U32MAX = 64'sh0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0, imm = '0, data1 = '0, data2 = '0;
    logic        alu_src = 1'b0, pc_src = 1'b0;
    logic [3:0]  alu_op = 4'b0;
    logic [31:0] norm_iaddr, branch_iaddr, alu_out, alu_q;
    logic        zero, carry, overflow, branch_taken;
    logic [2:0]  flags_q;

    int checks = 0;
    int errors = 0;

    exec_unit #(.WIDTH(32), .PC_INC(1)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .imm(imm), .data1(data1), .data2(data2),
        .alu_src(alu_src), .alu_op(alu_op), .pc_src(pc_src),
        .norm_iaddr(norm_iaddr), .branch_iaddr(branch_iaddr), .alu_out(alu_out),
        .zero(zero), .carry(carry), .overflow(overflow), .branch_taken(branch_taken),
        .alu_q(alu_q), .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    // Reference ALU built from integer arithmetic on 64-bit values.
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic c, output logic v);
        longint ua, ub, sa, sb, t;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; c = 1'b0; v = 1'b0; t = 0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2: begin
                t = ua + ub; r = t[31:0]; c = (t > U32MAX);
                t = sa + sb; v = (t > S32MAX) || (t < S32MIN);
            end
            4'd3:  r = a ^ b;
            4'd4: begin t = ua * (longint'(1) << b[4:0]); r = t[31:0]; end
            4'd5: begin t = ua / (longint'(1) << b[4:0]); r = t[31:0]; end
            4'd6: begin
                c = (ua >= ub); t = ua - ub; r = t[31:0];
                t = sa - sb; v = (t > S32MAX) || (t < S32MIN);
            end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8: begin t = sa >>> b[4:0]; r = t[31:0]; end
            4'd9:  r = (ua < ub) ? 32'd1 : 32'd0;
            4'd10: begin t = ub * 65536; r = t[31:0]; end
            4'd12: r = ~(a | b);
            default: r = '0;
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic src, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] pc, input logic ps);
        @(negedge clk);
        alu_op = op; alu_src = src; data1 = a; data2 = b; imm = im; pc_in = pc; pc_src = ps;
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        drive(ADD, 1'b0, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0);
        checks++; if (alu_q !== 32'h0) begin errors++; $display("FAIL reset_alu_q got %h exp %h", alu_q, 32'h0); end
        checks++; if (flags_q !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp %b", flags_q, 3'b000); end
        checks++; if (alu_out !== 32'd7) begin errors++; $display("FAIL reset_comb_alu got %h exp %h", alu_out, 32'd7); end
        @(posedge clk); #1;
        checks++; if (alu_q !== 32'h0) begin errors++; $display("FAIL reset_hold_alu_q got %h exp %h", alu_q, 32'h0); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_pc_adders();
        drive(ADD, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'h0000_0010, 1'b0);
        checks++; if (norm_iaddr !== 32'h11) begin errors++; $display("FAIL pc_norm got %h exp %h", norm_iaddr, 32'h11); end
        checks++; if (branch_iaddr !== 32'h0F) begin errors++; $display("FAIL pc_branch got %h exp %h", branch_iaddr, 32'h0F); end
        drive(ADD, 1'b0, 32'd0, 32'd0, 32'h0, 32'hFFFF_FFFF, 1'b0);
        checks++; if (norm_iaddr !== 32'h0) begin errors++; $display("FAIL pc_wrap got %h exp %h", norm_iaddr, 32'h0); end
        checks++; if (branch_iaddr !== 32'h0) begin errors++; $display("FAIL pc_wrap_branch got %h exp %h", branch_iaddr, 32'h0); end
    endtask

    task automatic test_add_sub();
        drive(ADD, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0);
        checks++; if (alu_out !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf_out got %h exp %h", alu_out, 32'h8000_0000); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL add_ovf_v got %b exp %b", overflow, 1'b1); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL add_ovf_c got %b exp %b", carry, 1'b0); end
        drive(ADD, 1'b0, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 1'b0);
        checks++; if (carry !== 1'b1) begin errors++; $display("FAIL add_carry got %b exp %b", carry, 1'b1); end
        drive(SUB, 1'b0, 32'd5, 32'd5, 32'h0, 32'h0, 1'b0);
        checks++; if (alu_out !== 32'h0) begin errors++; $display("FAIL sub_eq_out got %h exp %h", alu_out, 32'h0); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL sub_eq_z got %b exp %b", zero, 1'b1); end
        checks++; if (carry !== 1'b1) begin errors++; $display("FAIL sub_eq_c got %b exp %b", carry, 1'b1); end
        drive(SUB, 1'b0, 32'd0, 32'd1, 32'h0, 32'h0, 1'b0);
        checks++; if (alu_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_borrow_out got %h exp %h", alu_out, 32'hFFFF_FFFF); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL sub_borrow_c got %b exp %b", carry, 1'b0); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sub_borrow_v got %b exp %b", overflow, 1'b0); end
        drive(SUB, 1'b0, 32'h8000_0000, 32'h1, 32'h0, 32'h0, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sub_ovf_v got %b exp %b", overflow, 1'b1); end
    endtask

    task automatic test_branch();
        drive(SUB, 1'b0, 32'h2A, 32'h2A, 32'h0, 32'h0, 1'b1);
        checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL br_taken got %b exp %b", branch_taken, 1'b1); end
        drive(SUB, 1'b0, 32'h2A, 32'h2A, 32'h0, 32'h0, 1'b0);
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL br_nobranch got %b exp %b", branch_taken, 1'b0); end
        drive(SUB, 1'b0, 32'h2A, 32'h2B, 32'h0, 32'h0, 1'b1);
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL br_ne got %b exp %b", branch_taken, 1'b0); end
    endtask

    task automatic test_logic_imm();
        drive(SLT, 1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h1, 32'h0, 1'b0);
        checks++; if (alu_out !== 32'h1) begin errors++; $display("FAIL slt got %h exp %h", alu_out, 32'h1); end
        drive(SLTU, 1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h1, 32'h0, 1'b0);
        checks++; if (alu_out !== 32'h0) begin errors++; $display("FAIL sltu got %h exp %h", alu_out, 32'h0); end
        drive(SRA, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h24, 32'h0, 1'b0);
        checks++; if (alu_out !== 32'hF800_0000) begin errors++; $display("FAIL sra got %h exp %h", alu_out, 32'hF800_0000); end
        drive(LUI, 1'b1, 32'h5555_5555, 32'h0, 32'h1234, 32'h0, 1'b0);
        checks++; if (alu_out !== 32'h1234_0000) begin errors++; $display("FAIL lui got %h exp %h", alu_out, 32'h1234_0000); end
        drive(NOR, 1'b1, 32'h0, 32'hFFFF_0000, 32'h0, 32'h0, 1'b0);
        checks++; if (alu_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL nor got %h exp %h", alu_out, 32'hFFFF_FFFF); end
        drive(4'b1111, 1'b1, 32'h1234_5678, 32'h9, 32'h77, 32'h0, 1'b0);
        checks++; if (alu_out !== 32'h0) begin errors++; $display("FAIL undef_out got %h exp %h", alu_out, 32'h0); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL undef_z got %b exp %b", zero, 1'b1); end
    endtask

    task automatic test_register();
        drive(ADD, 1'b0, 32'd3, 32'd4, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        checks++; if (alu_q !== 32'd7) begin errors++; $display("FAIL reg_alu_q got %h exp %h", alu_q, 32'd7); end
        checks++; if (flags_q !== 3'b000) begin errors++; $display("FAIL reg_flags got %b exp %b", flags_q, 3'b000); end
        alu_op = SUB; data1 = 32'd5; data2 = 32'd5; #1;
        checks++; if (alu_q !== 32'd7) begin errors++; $display("FAIL reg_hold got %h exp %h", alu_q, 32'd7); end
        @(posedge clk); #1;
        checks++; if (alu_q !== 32'd0) begin errors++; $display("FAIL reg_next got %h exp %h", alu_q, 32'd0); end
        checks++; if (flags_q !== 3'b011) begin errors++; $display("FAIL reg_next_flags got %b exp %b", flags_q, 3'b011); end
    endtask

    task automatic test_async_reset();
        drive(ADD, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        checks++; if (flags_q !== 3'b100) begin errors++; $display("FAIL ar_load_flags got %b exp %b", flags_q, 3'b100); end
        #2 rst = 1'b0;
        #1;
        checks++; if (alu_q !== 32'h0) begin errors++; $display("FAIL ar_alu_q got %h exp %h", alu_q, 32'h0); end
        checks++; if (flags_q !== 3'b000) begin errors++; $display("FAIL ar_flags got %b exp %b", flags_q, 3'b000); end
        checks++; if (alu_out !== 32'h8000_0000) begin errors++; $display("FAIL ar_comb got %h exp %h", alu_out, 32'h8000_0000); end
        @(posedge clk); #1;
        checks++; if (alu_q !== 32'h0) begin errors++; $display("FAIL ar_held got %h exp %h", alu_q, 32'h0); end
        rst = 1'b1; #1;
        checks++; if (alu_q !== 32'h0) begin errors++; $display("FAIL ar_release got %h exp %h", alu_q, 32'h0); end
        @(posedge clk); #1;
        checks++; if (alu_q !== 32'h8000_0000) begin errors++; $display("FAIL ar_first_cap got %h exp %h", alu_q, 32'h8000_0000); end
        checks++; if (flags_q !== 3'b100) begin errors++; $display("FAIL ar_first_flags got %b exp %b", flags_q, 3'b100); end
    endtask

    task automatic test_random();
        logic [31:0] a, b, im, pc, bsel, er;
        logic [3:0]  op;
        logic        src, ps, ec, ev, ez;
        for (int i = 0; i < 300; i++) begin
            op  = 4'($urandom_range(0, 15));
            src = 1'($urandom);
            ps  = 1'($urandom);
            a   = $urandom; b = $urandom; im = $urandom; pc = $urandom;
            if ($urandom_range(0, 3) == 0) begin b = a; im = a; end
            if ($urandom_range(0, 3) == 0) begin a = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'h7FFF_FFFF}; end
            drive(op, src, a, b, im, pc, ps);
            bsel = src ? im : b;
            ref_alu(op, a, bsel, er, ec, ev);
            ez = (er == 32'h0);
            checks++; if (alu_out !== er) begin errors++; $display("FAIL rnd_out op=%h got %h exp %h", op, alu_out, er); end
            checks++; if ({overflow, carry, zero} !== {ev, ec, ez}) begin errors++; $display("FAIL rnd_flags op=%h got %b exp %b", op, {overflow, carry, zero}, {ev, ec, ez}); end
            checks++; if (branch_taken !== (ez & ps)) begin errors++; $display("FAIL rnd_branch got %b exp %b", branch_taken, ez & ps); end
            checks++; if (norm_iaddr !== 32'(pc + 32'd1)) begin errors++; $display("FAIL rnd_norm got %h exp %h", norm_iaddr, 32'(pc + 32'd1)); end
            checks++; if (branch_iaddr !== 32'(pc + 32'd1 + im)) begin errors++; $display("FAIL rnd_baddr got %h exp %h", branch_iaddr, 32'(pc + 32'd1 + im)); end
            @(posedge clk); #1;
            checks++; if (alu_q !== er) begin errors++; $display("FAIL rnd_alu_q got %h exp %h", alu_q, er); end
            checks++; if (flags_q !== {ev, ec, ez}) begin errors++; $display("FAIL rnd_flags_q got %b exp %b", flags_q, {ev, ec, ez}); end
        end
    endtask

    initial begin
        test_reset();
        test_pc_adders();
        test_add_sub();
        test_branch();
        test_logic_imm();
        test_register();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
